tgt_pyld_buf_mq: RTL and testbench

- Parametrised next-generation target payload buffer for the P2P path. Accepts payload beats, stores them in fixed-size blocks taken from an internal free-buffer list, and reports each filled block to control logic.
- Later returns each block beat-by-beat, in read mode or discard mode, and recycles the buffer.
- Adds configurable width, depth and block size, a real allocation handshake, per-queue occupancy limits, a discard mode, and a free-count output.

---
 rtl/tgt_pyld_buf_mq_if.sv | 47 ++++
 rtl/tgt_pyld_buf_mq.sv | 95 +++++++++
 tb/tb_tgt_pyld_buf_mq.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tgt_pyld_buf_mq_if.sv
// tgt_pyld_buf_mq_if: store, allocation, fetch/release and status signals of the target payload buffer
interface tgt_pyld_buf_mq_if #(
  parameter int DATA_W = 256,
  parameter int HEAD_W = 64,
  parameter int BUF_NUM_LOG = 10,
  parameter int BLK_BEATS_LOG = 2,
  parameter int NQ = 4
);
  localparam int QNUM_W = NQ > 1 ? $clog2(NQ) : 1;
  logic init_end;
  logic alloc_valid;
  logic alloc_last;
  logic [BUF_NUM_LOG-1:0] alloc_buf_addr;
  logic [QNUM_W-1:0] alloc_qnum;
  logic alloc_ready;
  logic st_valid;
  logic st_last;
  logic [QNUM_W-1:0] st_qnum;
  logic [DATA_W-1:0] st_data;
  logic st_ready;
  logic free_valid;
  logic free_last;
  logic free_rd;
  logic [HEAD_W-1:0] free_head;
  logic [BLK_BEATS_LOG-1:0] free_offset;
  logic [BUF_NUM_LOG-1:0] free_buf_addr;
  logic [QNUM_W-1:0] free_qnum;
  logic free_ready;
  logic ft_valid;
  logic ft_last;
  logic [HEAD_W-1:0] ft_head;
  logic [DATA_W-1:0] ft_data;
  logic ft_ready;
  logic [BUF_NUM_LOG:0] free_cnt;
  modport slave (
    output init_end, alloc_valid, alloc_last, alloc_buf_addr, alloc_qnum, st_ready,
           free_ready, ft_valid, ft_last, ft_head, ft_data, free_cnt,
    input  alloc_ready, st_valid, st_last, st_qnum, st_data, free_valid, free_last,
           free_rd, free_head, free_offset, free_buf_addr, free_qnum, ft_ready
  );
  modport master (
    input  init_end, alloc_valid, alloc_last, alloc_buf_addr, alloc_qnum, st_ready,
           free_ready, ft_valid, ft_last, ft_head, ft_data, free_cnt,
    output alloc_ready, st_valid, st_last, st_qnum, st_data, free_valid, free_last,
           free_rd, free_head, free_offset, free_buf_addr, free_qnum, ft_ready
  );
endinterface

// File: rtl/tgt_pyld_buf_mq.sv
// tgt_pyld_buf_mq: block payload buffer with free-list allocation, per-queue limits and read/discard release
module tgt_pyld_buf_mq #(
  parameter int DATA_W = 256,
  parameter int HEAD_W = 64,
  parameter int BUF_NUM_LOG = 10,
  parameter int BLK_BEATS_LOG = 2,
  parameter int NQ = 4,
  parameter int QCAP = 256
) (
  input logic clk,
  input logic rst_n,
  tgt_pyld_buf_mq_if.slave bus
);
  localparam int QNUM_W = NQ > 1 ? $clog2(NQ) : 1;
  localparam int NUM_BUF = 2 ** BUF_NUM_LOG;
  localparam int CW = BUF_NUM_LOG + 1;
  localparam int OCC_W = $clog2(QCAP + 1);
  localparam int AW = BUF_NUM_LOG + BLK_BEATS_LOG;
  logic [BUF_NUM_LOG-1:0] fl_mem [NUM_BUF];
  logic [BUF_NUM_LOG-1:0] fl_rd, fl_wr, head, push_addr;
  logic [CW-1:0] fl_cnt, init_idx;
  logic [BLK_BEATS_LOG-1:0] st_off;
  logic [OCC_W-1:0] occ [NQ];
  logic [NQ-1:0] inc, dec;
  logic [DATA_W-1:0] ram [2**AW];
  logic [DATA_W-1:0] rd_data;
  logic init_done, has_free, blk_last, q_block, st_hs, alloc_hs, fr_hs, rd_hs, rel, init_push, push;
  assign head = fl_mem[fl_rd];
  assign has_free = fl_cnt != '0;
  assign blk_last = (&st_off) | bus.st_last;
  assign q_block = (st_off == '0) && (occ[bus.st_qnum] == OCC_W'(QCAP));
  assign bus.init_end = init_done;
  assign bus.free_cnt = fl_cnt;
  assign bus.st_ready = init_done & has_free & ~q_block & (~blk_last | bus.alloc_ready);
  assign bus.alloc_valid = bus.st_valid & blk_last & init_done & has_free & ~q_block;
  assign bus.alloc_last = bus.st_last;
  assign bus.alloc_buf_addr = head;
  assign bus.alloc_qnum = bus.st_qnum;
  assign bus.free_ready = init_done & (~bus.ft_valid | bus.ft_ready);
  assign bus.ft_data = rd_data;
  assign st_hs = bus.st_valid & bus.st_ready;
  assign alloc_hs = st_hs & blk_last;
  assign fr_hs = bus.free_valid & bus.free_ready;
  assign rd_hs = fr_hs & bus.free_rd;
  assign rel = fr_hs & (bus.free_last | (&bus.free_offset));
  // init pushes and releases never overlap: releases need init_end
  assign init_push = ~init_idx[BUF_NUM_LOG];
  assign push = init_push | rel;
  assign push_addr = init_push ? init_idx[BUF_NUM_LOG-1:0] : bus.free_buf_addr;
  always_comb
    for (int i = 0; i < NQ; i++) begin
      inc[i] = alloc_hs && (bus.st_qnum == QNUM_W'(i));
      dec[i] = rel && (bus.free_qnum == QNUM_W'(i));
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init_idx <= '0;
      init_done <= 1'b0;
      fl_rd <= '0;
      fl_wr <= '0;
      fl_cnt <= '0;
      st_off <= '0;
      bus.ft_valid <= 1'b0;
      bus.ft_last <= 1'b0;
      bus.ft_head <= '0;
    end else begin
      init_idx <= init_idx + CW'(init_push);
      init_done <= init_idx[BUF_NUM_LOG];
      if (push) fl_wr <= fl_wr + BUF_NUM_LOG'(1);
      if (alloc_hs) fl_rd <= fl_rd + BUF_NUM_LOG'(1);
      fl_cnt <= fl_cnt + CW'(push) - CW'(alloc_hs);
      if (st_hs) st_off <= blk_last ? '0 : st_off + BLK_BEATS_LOG'(1);
      if (rd_hs) begin
        bus.ft_valid <= 1'b1;
        bus.ft_last <= bus.free_last;
        bus.ft_head <= bus.free_head;
      end else if (bus.ft_ready) begin
        bus.ft_valid <= 1'b0;
        bus.ft_last <= 1'b0;
        bus.ft_head <= '0;
      end
    end
  // a queue allocating and releasing in the same cycle keeps its count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) occ <= '{default: '0};
    else
      for (int i = 0; i < NQ; i++)
        if (inc[i] && !dec[i] && occ[i] != OCC_W'(QCAP)) occ[i] <= occ[i] + OCC_W'(1);
        else if (dec[i] && !inc[i] && occ[i] != '0) occ[i] <= occ[i] - OCC_W'(1);
  always_ff @(posedge clk) begin
    if (push) fl_mem[fl_wr] <= push_addr;
    if (st_hs) ram[{head, st_off}] <= bus.st_data;
    if (rd_hs) rd_data <= ram[{bus.free_buf_addr, bus.free_offset}];
  end
endmodule

// File: tb/tb_tgt_pyld_buf_mq.sv
// tb_tgt_pyld_buf_mq: directed scenarios for the target payload buffer (16 buffers, 4-beat blocks, QCAP=2)
module tb_tgt_pyld_buf_mq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  tgt_pyld_buf_mq_if #(.DATA_W(32), .HEAD_W(16), .BUF_NUM_LOG(4), .BLK_BEATS_LOG(2), .NQ(4)) bus ();
  tgt_pyld_buf_mq #(.DATA_W(32), .HEAD_W(16), .BUF_NUM_LOG(4), .BLK_BEATS_LOG(2), .NQ(4), .QCAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic idle;
    bus.alloc_ready = 0; bus.st_valid = 0; bus.st_last = 0; bus.st_qnum = 0; bus.st_data = 0;
    bus.free_valid = 0; bus.free_last = 0; bus.free_rd = 0; bus.free_head = 0; bus.free_offset = 0;
    bus.free_buf_addr = 0; bus.free_qnum = 0; bus.ft_ready = 0;
  endtask

  task automatic put_beat(input logic [1:0] q, input logic last, input logic [31:0] d,
                          output logic av, output logic al, output logic [3:0] ab, output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    bus.st_valid = 1; bus.st_qnum = q; bus.st_last = last; bus.st_data = d;
    #1;
    while (!bus.st_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    ok = bus.st_ready; av = bus.alloc_valid; al = bus.alloc_last; ab = bus.alloc_buf_addr;
    @(posedge clk); #1;
    bus.st_valid = 0;
  endtask

  task automatic test_reset;
    int n;
    idle();
    bus.alloc_ready = 1; bus.st_valid = 1; bus.st_last = 1; bus.free_valid = 1; bus.ft_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if ({bus.init_end, bus.ft_valid, bus.ft_last, bus.ft_head} !== 19'd0) begin
      errs++; $display("FAIL reset_regs: init_end=%b ft_valid=%b ft_last=%b ft_head=%h, want all 0", bus.init_end, bus.ft_valid, bus.ft_last, bus.ft_head);
    end
    vecs++; if ({bus.st_ready, bus.free_ready, bus.alloc_valid} !== 3'b000 || bus.free_cnt !== 5'd0) begin
      errs++; $display("FAIL reset_hs: st_ready=%b free_ready=%b alloc_valid=%b free_cnt=%0d, want 0", bus.st_ready, bus.free_ready, bus.alloc_valid, bus.free_cnt);
    end
    idle();
    @(negedge clk); rst_n = 1;
    n = 0;
    while (!bus.init_end && n < 100) begin
      @(posedge clk); #1; n++;
      if (n == 16) begin
        vecs++; if (bus.free_cnt !== 5'd16 || bus.init_end !== 1'b0) begin
          errs++; $display("FAIL init_push16: free_cnt=%0d init_end=%b, want 16/0", bus.free_cnt, bus.init_end);
        end
      end
    end
    vecs++; if (n != 17 || bus.free_cnt !== 5'd16 || bus.alloc_buf_addr !== 4'd0) begin
      errs++; $display("FAIL init_end: cycles=%0d free_cnt=%0d head=%0d, want 17/16/0", n, bus.free_cnt, bus.alloc_buf_addr);
    end
  endtask

  task automatic test_store;
    logic av, al, ok;
    logic [3:0] ab;
    bus.alloc_ready = 1;
    for (int i = 0; i < 6; i++) begin
      put_beat(2'd1, i == 5, 32'hA000_0000 + i, av, al, ab, ok);
      vecs++; if (!ok || av !== (i == 3 || i == 5)) begin
        errs++; $display("FAIL store_alloc_valid beat %0d: ok=%b alloc_valid=%b, want 1/%b", i, ok, av, i == 3 || i == 5);
      end
      if (i == 3 || i == 5) begin
        vecs++; if ({al, ab} !== {i == 5, i == 3 ? 4'd0 : 4'd1}) begin
          errs++; $display("FAIL store_alloc beat %0d: last=%b buf=%0d, want %b/%0d", i, al, ab, i == 5, i == 3 ? 0 : 1);
        end
      end
    end
    @(negedge clk);
    bus.st_valid = 1; bus.st_qnum = 1; bus.st_last = 1;
    #1;
    vecs++; if (bus.free_cnt !== 5'd14 || bus.st_ready !== 1'b0 || bus.alloc_valid !== 1'b0) begin
      errs++; $display("FAIL store_after: free_cnt=%0d q1 st_ready=%b alloc_valid=%b, want 14/0/0", bus.free_cnt, bus.st_ready, bus.alloc_valid);
    end
    bus.st_valid = 0;
  endtask

  task automatic test_fetch;
    logic [31:0] got_d[$];
    logic [15:0] got_h[$];
    logic got_l[$];
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int n;
          n = 0;
          @(negedge clk);
          bus.free_valid = 1; bus.free_rd = 1; bus.free_buf_addr = 0; bus.free_offset = 2'(i);
          bus.free_qnum = 1; bus.free_last = (i == 3); bus.free_head = 16'(16'h100 + i);
          #1;
          while (!bus.free_ready && n < 20) begin
            @(negedge clk); #1; n++;
          end
          @(posedge clk); #1;
          bus.free_valid = 0;
        end
      end
      begin
        for (int c = 0; c < 40 && got_d.size() < 4; c++) begin
          @(negedge clk);
          bus.ft_ready = c[0];
          #1;
          if (bus.ft_valid && bus.ft_ready) begin
            got_d.push_back(bus.ft_data); got_h.push_back(bus.ft_head); got_l.push_back(bus.ft_last);
          end
        end
      end
    join
    vecs++; if (got_d.size() != 4) begin
      errs++; $display("FAIL fetch_count: got %0d beats, want 4", got_d.size());
    end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      vecs++; if ({got_d[i], got_h[i], got_l[i]} !== {32'hA000_0000 + i, 16'(16'h100 + i), i == 3}) begin
        errs++; $display("FAIL fetch_beat %0d: data=%h head=%h last=%b, want %h/%h/%b", i, got_d[i], got_h[i], got_l[i], 32'hA000_0000 + i, 16'(16'h100 + i), i == 3);
      end
    end
    bus.ft_ready = 1;
    @(posedge clk); #1;
    vecs++; if ({bus.ft_valid, bus.ft_last, bus.ft_head} !== 18'd0) begin
      errs++; $display("FAIL fetch_clear: ft_valid=%b ft_last=%b ft_head=%h, want 0", bus.ft_valid, bus.ft_last, bus.ft_head);
    end
    vecs++; if (bus.free_cnt !== 5'd15 || bus.alloc_buf_addr !== 4'd2) begin
      errs++; $display("FAIL fetch_release: free_cnt=%0d head=%0d, want 15/2", bus.free_cnt, bus.alloc_buf_addr);
    end
  endtask

  task automatic test_qcap;
    logic av, al, ok;
    logic [3:0] ab;
    bus.alloc_ready = 1;
    for (int i = 0; i < 2; i++) begin
      put_beat(2'd2, 1'b1, 32'hB0 + i, av, al, ab, ok);
      vecs++; if (!ok || !av || ab !== 4'(2 + i)) begin
        errs++; $display("FAIL qcap_fill %0d: ok=%b alloc_valid=%b buf=%0d, want 1/1/%0d", i, ok, av, ab, 2 + i);
      end
    end
    @(negedge clk);
    bus.st_valid = 1; bus.st_qnum = 2; bus.st_last = 1; bus.st_data = 32'hB2;
    repeat (3) begin
      #1;
      vecs++; if (bus.st_ready !== 1'b0 || bus.alloc_valid !== 1'b0) begin
        errs++; $display("FAIL qcap_block: st_ready=%b alloc_valid=%b, want 0/0", bus.st_ready, bus.alloc_valid);
      end
      @(negedge clk);
    end
    bus.st_qnum = 3; bus.st_data = 32'hB3;
    #1;
    vecs++; if (bus.st_ready !== 1'b1 || bus.alloc_valid !== 1'b1 || bus.alloc_buf_addr !== 4'd4) begin
      errs++; $display("FAIL qcap_other_q: st_ready=%b alloc_valid=%b buf=%0d, want 1/1/4", bus.st_ready, bus.alloc_valid, bus.alloc_buf_addr);
    end
    @(posedge clk);
    @(negedge clk);
    bus.st_qnum = 2; bus.st_data = 32'hB2;
    bus.free_valid = 1; bus.free_rd = 0; bus.free_buf_addr = 2; bus.free_offset = 0;
    bus.free_last = 1; bus.free_qnum = 2; bus.ft_ready = 1;
    #1;
    vecs++; if (bus.free_ready !== 1'b1 || bus.st_ready !== 1'b0) begin
      errs++; $display("FAIL qcap_release: free_ready=%b st_ready=%b, want 1/0", bus.free_ready, bus.st_ready);
    end
    @(posedge clk); #1;
    bus.free_valid = 0;
    vecs++; if (bus.st_ready !== 1'b1 || bus.alloc_buf_addr !== 4'd5 || bus.free_cnt !== 5'd13) begin
      errs++; $display("FAIL qcap_unblock: st_ready=%b buf=%0d free_cnt=%0d, want 1/5/13", bus.st_ready, bus.alloc_buf_addr, bus.free_cnt);
    end
    @(posedge clk); #1;
    bus.st_valid = 0;
    vecs++; if (bus.free_cnt !== 5'd12) begin
      errs++; $display("FAIL qcap_cnt: free_cnt=%0d, want 12", bus.free_cnt);
    end
  endtask

  task automatic test_discard;
    logic av, al, ok;
    logic [3:0] ab;
    bus.ft_ready = 1; bus.alloc_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.free_valid = 1; bus.free_rd = 0; bus.free_buf_addr = 1; bus.free_offset = 2'(i);
      bus.free_qnum = 1; bus.free_last = 0; bus.free_head = 16'hDEAD;
      if (i == 3) begin
        bus.st_valid = 1; bus.st_qnum = 1; bus.st_last = 1; bus.st_data = 32'hC0;
      end
      #1;
      vecs++; if (bus.free_ready !== 1'b1) begin
        errs++; $display("FAIL discard_ready %0d: free_ready=%b, want 1", i, bus.free_ready);
      end
      if (i == 3) begin
        vecs++; if ({bus.alloc_valid, bus.st_ready} !== 2'b11 || bus.alloc_buf_addr !== 4'd6) begin
          errs++; $display("FAIL discard_alloc: alloc_valid=%b st_ready=%b buf=%0d, want 1/1/6", bus.alloc_valid, bus.st_ready, bus.alloc_buf_addr);
        end
      end
      @(posedge clk); #1;
      vecs++; if (bus.ft_valid !== 1'b0) begin
        errs++; $display("FAIL discard_ft %0d: ft_valid=%b, want 0", i, bus.ft_valid);
      end
    end
    bus.free_valid = 0; bus.st_valid = 0;
    vecs++; if (bus.free_cnt !== 5'd12) begin
      errs++; $display("FAIL discard_cnt: free_cnt=%0d, want 12", bus.free_cnt);
    end
    put_beat(2'd1, 1'b1, 32'hC1, av, al, ab, ok);
    vecs++; if (!ok || !av || ab !== 4'd7) begin
      errs++; $display("FAIL discard_occ_room: ok=%b alloc_valid=%b buf=%0d, want 1/1/7", ok, av, ab);
    end
    @(negedge clk);
    bus.st_valid = 1; bus.st_qnum = 1; bus.st_last = 1;
    #1;
    vecs++; if (bus.st_ready !== 1'b0) begin
      errs++; $display("FAIL discard_occ_full: st_ready=%b, want 0", bus.st_ready);
    end
    bus.st_valid = 0;
  endtask

  task automatic test_stall_alloc;
    logic av, al, ok;
    logic [3:0] ab;
    bus.alloc_ready = 1;
    for (int i = 0; i < 3; i++) begin
      put_beat(2'd0, 1'b0, 32'hE0 + i, av, al, ab, ok);
      vecs++; if (!ok || av !== 1'b0) begin
        errs++; $display("FAIL stall_pre %0d: ok=%b alloc_valid=%b, want 1/0", i, ok, av);
      end
    end
    @(negedge clk);
    bus.st_valid = 1; bus.st_qnum = 0; bus.st_last = 0; bus.st_data = 32'hE3; bus.alloc_ready = 0;
    repeat (3) begin
      #1;
      vecs++; if ({bus.st_ready, bus.alloc_valid} !== 2'b01 || bus.alloc_buf_addr !== 4'd8 || bus.free_cnt !== 5'd11) begin
        errs++; $display("FAIL stall_hold: st_ready=%b alloc_valid=%b buf=%0d free_cnt=%0d, want 0/1/8/11", bus.st_ready, bus.alloc_valid, bus.alloc_buf_addr, bus.free_cnt);
      end
      @(negedge clk);
    end
    bus.alloc_ready = 1;
    #1;
    vecs++; if ({bus.st_ready, bus.alloc_valid} !== 2'b11) begin
      errs++; $display("FAIL stall_release: st_ready=%b alloc_valid=%b, want 1/1", bus.st_ready, bus.alloc_valid);
    end
    @(posedge clk); #1;
    bus.st_valid = 0;
    vecs++; if (bus.free_cnt !== 5'd10) begin
      errs++; $display("FAIL stall_cnt: free_cnt=%0d, want 10", bus.free_cnt);
    end
  endtask

  task automatic test_back_to_back;
    bus.ft_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.free_valid = (i < 4); bus.free_rd = 1; bus.free_buf_addr = 8; bus.free_offset = 2'(i);
      bus.free_qnum = 0; bus.free_last = (i == 3); bus.free_head = 16'(16'h200 + i);
      #1;
      if (i < 4) begin
        vecs++; if (bus.free_ready !== 1'b1) begin
          errs++; $display("FAIL b2b_ready %0d: free_ready=%b, want 1", i, bus.free_ready);
        end
      end
      if (i > 0) begin
        vecs++; if ({bus.ft_valid, bus.ft_data, bus.ft_head, bus.ft_last} !== {1'b1, 32'(32'hE0 + i - 1), 16'(16'h200 + i - 1), i == 4}) begin
          errs++; $display("FAIL b2b_beat %0d: valid=%b data=%h head=%h last=%b, want 1/%h/%h/%b", i - 1, bus.ft_valid, bus.ft_data, bus.ft_head, bus.ft_last, 32'(32'hE0 + i - 1), 16'(16'h200 + i - 1), i == 4);
        end
      end
      @(posedge clk); #1;
    end
    vecs++; if (bus.ft_valid !== 1'b0 || bus.free_cnt !== 5'd11) begin
      errs++; $display("FAIL b2b_end: ft_valid=%b free_cnt=%0d, want 0/11", bus.ft_valid, bus.free_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic av, al, ok;
    logic [3:0] ab;
    int n;
    bus.alloc_ready = 1;
    put_beat(2'd0, 1'b0, 32'hF0, av, al, ab, ok);
    @(negedge clk);
    bus.free_valid = 1; bus.free_rd = 1; bus.free_buf_addr = 9; bus.free_offset = 0;
    bus.free_qnum = 0; bus.free_last = 1; bus.free_head = 16'h3AA; bus.ft_ready = 0;
    @(posedge clk); #1;
    bus.free_valid = 0;
    vecs++; if (bus.ft_valid !== 1'b1 || bus.ft_head !== 16'h3AA) begin
      errs++; $display("FAIL mid_pre: ft_valid=%b ft_head=%h, want 1/3aa", bus.ft_valid, bus.ft_head);
    end
    bus.st_valid = 1; bus.st_last = 1;
    #1 rst_n = 0;
    #1;
    vecs++; if ({bus.init_end, bus.ft_valid, bus.ft_last, bus.ft_head, bus.free_cnt} !== 24'd0) begin
      errs++; $display("FAIL mid_reset_regs: init_end=%b ft_valid=%b ft_last=%b ft_head=%h free_cnt=%0d, want 0", bus.init_end, bus.ft_valid, bus.ft_last, bus.ft_head, bus.free_cnt);
    end
    vecs++; if ({bus.st_ready, bus.free_ready, bus.alloc_valid} !== 3'b000) begin
      errs++; $display("FAIL mid_reset_hs: st_ready=%b free_ready=%b alloc_valid=%b, want 0", bus.st_ready, bus.free_ready, bus.alloc_valid);
    end
    bus.st_valid = 0; bus.st_last = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    n = 0;
    while (!bus.init_end && n < 100) begin
      @(posedge clk); #1; n++;
    end
    vecs++; if (n != 17 || bus.free_cnt !== 5'd16 || bus.alloc_buf_addr !== 4'd0) begin
      errs++; $display("FAIL mid_reinit: cycles=%0d free_cnt=%0d head=%0d, want 17/16/0", n, bus.free_cnt, bus.alloc_buf_addr);
    end
    for (int i = 0; i < 4; i++) begin
      put_beat(2'd0, 1'b0, 32'h50 + i, av, al, ab, ok);
      vecs++; if (!ok || av !== (i == 3) || (i == 3 && ab !== 4'd0)) begin
        errs++; $display("FAIL mid_offset beat %0d: ok=%b alloc_valid=%b buf=%0d, want 1/%b/0", i, ok, av, ab, i == 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_fetch();
    test_qcap();
    test_discard();
    test_stall_alloc();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
